// File: rtl/data_mem_if.sv
// Request/response bundle between a load/store unit and data_mem_ctrl.
// The requester drives the master side; the memory controller is the slave.
interface data_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Little-endian byte/half/word data memory with registered, handshaked responses.
// Misaligned accesses are split into two word beats or rejected, per MISALIGN_SPLIT.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS    = 16,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input logic   clk,
  input logic   rst,
  data_mem_if.slave bus
);
  localparam int              IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC1 = 2'd1;
  localparam logic [1:0] S_ACC2 = 2'd2;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic sgn);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] bx;
    logic signed [31:0] hx;
    b8  = raw[7:0];
    h16 = raw[15:0];
    bx  = b8;
    hx  = h16;
    case (size)
      2'b00:   extend = sgn ? bx : {24'b0, raw[7:0]};
      2'b01:   extend = sgn ? hx : {16'b0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  logic [1:0]  state;
  logic [31:0] mem [DEPTH_WORDS];

  logic              accept;
  logic [1:0]        nb_m1;
  logic [3:0]        lane_mask;
  logic [ADDR_W:0]   last_byte;
  logic              span;
  logic              err_req;

  logic              write_p0;
  logic [1:0]        size_p0;
  logic              sgn_p0;
  logic [1:0]        off_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic              err_p0;
  logic              split_p0;
  logic [63:0]       wide_p0;
  logic [7:0]        be_p0;
  logic [31:0]       lo_p1;

  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       rd_word;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [63:0]       window;
  logic [31:0]       load_data;

  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign accept         = bus.req_valid && (state == S_IDLE);

  // Acceptance decode: the last touched byte is computed one bit wider so that
  // addresses near the top of the address space cannot wrap back into range.
  always_comb begin
    case (bus.req_size)
      2'b00:   begin nb_m1 = 2'd0; lane_mask = 4'b0001; end
      2'b01:   begin nb_m1 = 2'd1; lane_mask = 4'b0011; end
      default: begin nb_m1 = 2'd3; lane_mask = 4'b1111; end
    endcase
    last_byte = {1'b0, bus.req_addr} + {{(ADDR_W-1){1'b0}}, nb_m1};
    span      = (last_byte[ADDR_W:2] != {1'b0, bus.req_addr[ADDR_W-1:2]});
    err_req   = (bus.req_size == 2'b11) || (last_byte >= BYTES) ||
                (span && !MISALIGN_SPLIT);
  end

  // Stage p0: request captured at acceptance, store data pre-aligned onto 8 lanes
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= bus.req_write;
      size_p0  <= bus.req_size;
      sgn_p0   <= bus.req_signed;
      off_p0   <= bus.req_addr[1:0];
      idx_p0   <= bus.req_addr[IDX_W+1:2];
      err_p0   <= err_req;
      split_p0 <= span && !err_req;
      wide_p0  <= {32'b0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
      be_p0    <= {4'b0, lane_mask} << bus.req_addr[1:0];
    end
    // Stage p1: first-beat word held for merging in ACC2
    if (state == S_ACC1) begin
      lo_p1 <= rd_word;
    end
  end

  always_comb begin
    acc_idx = (state == S_ACC2) ? idx_p0 + IDX_W'(1) : idx_p0;
    rd_word = mem[acc_idx];
    wr_be   = (state == S_ACC2) ? be_p0[7:4] : be_p0[3:0];
    wr_data = (state == S_ACC2) ? wide_p0[63:32] : wide_p0[31:0];
    wr_en   = !rst && write_p0 && !err_p0 && (state == S_ACC1 || state == S_ACC2);
    window    = split_p0 ? {rd_word, lo_p1} : {32'b0, rd_word};
    load_data = extend(32'(window >> {off_p0, 3'b000}), size_p0, sgn_p0);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Stage p2: response registered on the edge that returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_ACC1;
          end
        end
        S_ACC1: begin
          if (split_p0) begin
            state <= S_ACC2;
          end else begin
            state        <= S_IDLE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_p0;
            resp_rdata_q <= (err_p0 || write_p0) ? '0 : load_data;
          end
        end
        S_ACC2: begin
          state        <= S_IDLE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= write_p0 ? '0 : load_data;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a split instance and a reject-misaligned instance
// share stimulus; each is compared to a byte-array model plus directed vectors.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v, w, sg;
  logic [1:0]  sz;
  logic [31:0] a, wd;

  data_mem_if #(.ADDR_W(32)) bus_s ();
  data_mem_if #(.ADDR_W(32)) bus_e ();

  assign bus_s.req_valid  = v;
  assign bus_s.req_write  = w;
  assign bus_s.req_size   = sz;
  assign bus_s.req_signed = sg;
  assign bus_s.req_addr   = a;
  assign bus_s.req_wdata  = wd;
  assign bus_e.req_valid  = v;
  assign bus_e.req_write  = w;
  assign bus_e.req_size   = sz;
  assign bus_e.req_signed = sg;
  assign bus_e.req_addr   = a;
  assign bus_e.req_wdata  = wd;

  data_mem_ctrl #(.DEPTH_WORDS(16), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s));
  data_mem_ctrl #(.DEPTH_WORDS(16), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_e (
    .clk(clk), .rst(rst), .bus(bus_e));

  int n_vec = 0;
  int n_err = 0;

  // index 0 models the split instance, index 1 the reject instance
  logic [7:0] mem_m [2][64];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;

  localparam int NT = 18;
  vec_t tbl [NT];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic model(input int k, input logic wi, input logic [1:0] szi, input logic sgi,
                       input logic [31:0] ai, input logic [31:0] wdi,
                       output logic [31:0] rd, output logic er, output int lat);
    int n;
    longint unsigned first, last;
    logic [31:0] val;
    bit spans;
    n     = (szi == 2'd0) ? 1 : (szi == 2'd1) ? 2 : 4;
    first = {32'b0, ai};
    last  = first + longint'(n) - 1;
    spans = (first >> 2) != (last >> 2);
    rd    = '0;
    er    = 1'b0;
    lat   = spans ? 3 : 2;
    if (szi == 2'd3 || last >= 64 || (spans && k == 1)) begin
      er  = 1'b1;
      lat = 2;
    end else if (wi) begin
      for (int i = 0; i < n; i++) mem_m[k][int'(first) + i] = wdi[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = mem_m[k][int'(first) + i];
      if (sgi && n < 4 && val[8*n-1]) begin
        for (int j = 8*n; j < 32; j++) val[j] = 1'b1;
      end
      rd = val;
    end
  endtask

  task automatic do_req(input string nm, input logic wi, input logic [1:0] szi,
                        input logic sgi, input logic [31:0] ai, input logic [31:0] wdi,
                        input bit use_tbl, input logic [31:0] t_rd, input logic t_er,
                        input int t_lat);
    logic [31:0] ms_rd, me_rd, es_rd, got_s_rd, got_e_rd;
    logic        ms_er, me_er, es_er, got_s_er, got_e_er;
    int          ms_lat, me_lat, es_lat, lat_s, lat_e, ps, pe;
    model(0, wi, szi, sgi, ai, wdi, ms_rd, ms_er, ms_lat);
    model(1, wi, szi, sgi, ai, wdi, me_rd, me_er, me_lat);
    es_rd  = use_tbl ? t_rd  : ms_rd;
    es_er  = use_tbl ? t_er  : ms_er;
    es_lat = use_tbl ? t_lat : ms_lat;
    chk({nm, " ready"}, {31'b0, bus_s.req_ready && bus_e.req_ready}, 32'd1);
    w = wi; sz = szi; sg = sgi; a = ai; wd = wdi; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    lat_s = 0; lat_e = 0; ps = 0; pe = 0;
    got_s_rd = '0; got_e_rd = '0; got_s_er = 1'b0; got_e_er = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus_s.resp_valid) begin
        ps++;
        if (lat_s == 0) begin lat_s = c; got_s_rd = bus_s.resp_rdata; got_s_er = bus_s.resp_err; end
      end
      if (bus_e.resp_valid) begin
        pe++;
        if (lat_e == 0) begin lat_e = c; got_e_rd = bus_e.resp_rdata; got_e_er = bus_e.resp_err; end
      end
      if (lat_s != 0 && lat_e != 0) break;
    end
    chk({nm, " split latency"}, 32'(lat_s), 32'(es_lat));
    chk({nm, " split rdata"}, got_s_rd, es_rd);
    chk({nm, " split err"}, {31'b0, got_s_er}, {31'b0, es_er});
    chk({nm, " split pulses"}, 32'(ps), 32'd1);
    chk({nm, " reject latency"}, 32'(lat_e), 32'(me_lat));
    chk({nm, " reject rdata"}, got_e_rd, me_rd);
    chk({nm, " reject err"}, {31'b0, got_e_er}, {31'b0, me_er});
    chk({nm, " reject pulses"}, 32'(pe), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h0B, 32'h0,        32'hFFFFFFDE, 1'b0, 2};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0,        32'h000000DE, 1'b0, 2};
    tbl[4]  = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        32'hFFFFDEAD, 1'b0, 2};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        32'h0000BEEF, 1'b0, 2};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h000000AB, 32'h00000000, 1'b0, 2};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'hDEADABEF, 1'b0, 2};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h00000000, 32'h00000000, 1'b0, 2};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h06, 32'h11223344, 32'h00000000, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h33440000, 1'b0, 2};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h00001122, 1'b0, 2};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        32'h11223344, 1'b0, 3};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h3E, 32'h0,        32'h00000000, 1'b1, 2};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h3E, 32'hCAFEF00D, 32'h00000000, 1'b1, 2};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,        32'h00000000, 1'b0, 2};
    tbl[16] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b1, 2};
    tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        32'h00000000, 1'b0, 3};

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) mem_m[k][i] = 8'h00;
    v = 1'b0; w = 1'b0; sz = 2'd0; sg = 1'b0; a = '0; wd = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready s", {31'b0, bus_s.req_ready}, 32'd1);
    chk("reset valid s", {31'b0, bus_s.resp_valid}, 32'd0);
    chk("reset rdata s", bus_s.resp_rdata, 32'd0);
    chk("reset err s", {31'b0, bus_s.resp_err}, 32'd0);
    chk("reset ready e", {31'b0, bus_e.req_ready}, 32'd1);
    chk("reset valid e", {31'b0, bus_e.resp_valid}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      do_req($sformatf("zero%0d", i), 1'b1, 2'd2, 1'b0, 32'(4*i), 32'h0, 1'b0, '0, 1'b0, 0);

    for (int i = 0; i < NT; i++)
      do_req($sformatf("tbl%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
             1'b1, tbl[i].rd, tbl[i].er, tbl[i].lat);

    // Split store interrupted by reset in its second beat
    do_req("pre04", 1'b1, 2'd2, 1'b0, 32'h04, 32'h00000000, 1'b0, '0, 1'b0, 0);
    do_req("pre08", 1'b1, 2'd2, 1'b0, 32'h08, 32'hA5A5A5A5, 1'b0, '0, 1'b0, 0);
    w = 1'b1; sz = 2'd2; sg = 1'b0; a = 32'h06; wd = 32'h11223344; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("rst acc2 no resp before", {31'b0, bus_s.resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst acc2 no resp after", {31'b0, bus_s.resp_valid}, 32'd0);
    chk("rst acc2 ready s", {31'b0, bus_s.req_ready}, 32'd1);
    chk("rst acc2 ready e", {31'b0, bus_e.req_ready}, 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus_s.resp_valid;
    end
    chk("rst acc2 quiet", {31'b0, seen}, 32'd0);
    mem_m[0][6] = 8'h44;
    mem_m[0][7] = 8'h33;
    do_req("rst lw04", 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 1'b1, 32'h33440000, 1'b0, 2);
    do_req("rst lw08", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 2);

    for (int i = 0; i < 250; i++) begin
      logic        rw, rsg;
      logic [1:0]  rsz;
      logic [31:0] ra, rwd;
      rw  = 1'($urandom);
      rsg = 1'($urandom);
      rsz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                        : 32'($urandom_range(0, 66));
      rwd = $urandom;
      do_req($sformatf("rnd%0d", i), rw, rsz, rsg, ra, rwd, 1'b0, '0, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked successor to the single-cycle byte-addressed data memory. It is a little-endian data memory of configurable depth with registered responses, byte/half/word accesses, and optional sign extension. Misaligned accesses are either split into two word beats or rejected. It sits between the load/store unit of the multi-cycle/pipelined core and on-chip RAM, and reports out-of-range and illegal accesses instead of silently aliasing.

## Interface
- DEPTH_WORDS, 16: number of 32-bit words; byte capacity is 4*DEPTH_WORDS. Must be a power of two, ≥2.
- ADDR_W, 32: width of the byte address.
- MISALIGN_SPLIT, 1: 1 = split misaligned accesses into two beats; 0 = respond with error.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: sign-extend byte/half; ignored for word and stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; 1 = access rejected.

## Operation
- Storage is DEPTH_WORDS x 4 byte lanes, little-endian. Byte b of word w is at address 4w+b. Reset does not clear contents.
- A request is accepted when req_valid && req_ready. All request fields are captured at acceptance and do not need to be held.
- Error conditions (checked at acceptance):
  - req_size==11;
  - any touched byte ≥ 4*DEPTH_WORDS (no wrap-around);
  - misaligned with MISALIGN_SPLIT=0.
- Errors perform no memory access and return resp_err=1, resp_rdata=0.
- Misaligned means the touched bytes span two words: half at offset 3, or word at offset ≠0.
- Stores modify only the touched bytes. All other lanes are preserved.
- Loads assemble the touched bytes with the lowest address in bit 0. Byte/half results are zero-extended, or sign-extended when req_signed=1.
- FSM states:
  - IDLE (req_ready=1). On accept: → ACC1.
  - ACC1: accesses the word containing the first byte. If not split, registers the response and goes → IDLE. If split, → ACC2. Error requests register the error response and go → IDLE.
  - ACC2: accesses the next word (word index +1), merges with the ACC1 bytes, registers the response, and goes → IDLE.
- The response registers are loaded on the edge entering IDLE from ACC1/ACC2. resp_valid stays high for exactly that one cycle.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE.
- Latency, with acceptance at edge T:
  - aligned or error: resp_valid high in the cycle after edge T+1;
  - split: resp_valid high in the cycle after edge T+2.
- Throughput: one aligned request per 2 cycles, one split request per 3. A new request may be accepted in the same cycle resp_valid is high.
- Store data is visible to any load accepted afterwards; a back-to-back load returns the new data.
- rst asserted in ACC1/ACC2: next state is IDLE and no response is issued. In a split store interrupted in ACC2, first-word bytes written at the ACC1 edge remain and second-word bytes are not written.
- req_valid while req_ready=0 is ignored; requesters must hold until accepted.

## Test plan
- Store word 0xDEADBEEF @0x08, then load word @0x08. Required: resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after acceptance.
- Subword loads after the test above:
  - byte @0x0B signed → 0xFFFFFFDE;
  - byte @0x0B unsigned → 0x000000DE;
  - half @0x0A signed → 0xFFFFDEAD;
  - half @0x08 unsigned → 0x0000BEEF.
- On zeroed memory, MISALIGN_SPLIT=1: store word 0x11223344 @0x06 responds after 3 cycles. Then load word @0x04 → 0x33440000 and load word @0x08 → 0x00001122. Load word @0x06 → 0x11223344, also in 3 cycles.
- DEPTH_WORDS=16: load word @0x3E → resp_err=1, resp_rdata=0. Store word @0x3E → resp_err=1, and bytes 0x3C–0x3F are unchanged. req_size=11 → resp_err=1. With MISALIGN_SPLIT=0, half @0x03 → resp_err=1.
- Byte store 0xAB @0x09 over word 0xDEADBEEF @0x08 → load word @0x08 returns 0xDEADABEF.
- Split store 0x11223344 @0x06 with rst asserted during ACC2:
  - no resp_valid;
  - state returns to IDLE with req_ready=1;
  - bytes 0x06/0x07 = 0x44/0x33;
  - bytes 0x08/0x09 are unchanged.
